// File: rtl/fetch_pkg.sv
// Shared constants, types and the branch-target helper for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] PC_OFFSET        = 32'd8;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ARM_NOP          = 32'hE1A0_0000;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // The ARM PC reads two words ahead of the branch; the result is forced word-aligned.
    function automatic logic [31:0] branch_target(input logic [31:0] branch_pc,
                                                  input logic [31:0] ext_imm);
        return (branch_pc + PC_OFFSET + ext_imm) & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {instr, pc} queue with synchronous clear and same-cycle push/pop.
// Head outputs come straight from the entry-0 register.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic [1:0]  count_o
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;
    logic [1:0]   occ_after_pop;
    logic         empty, full;
    logic         do_push, do_pop;

    assign empty         = (count_q == 2'd0);
    assign full          = (count_q == 2'd2);
    assign do_pop        = pop_i && !empty;
    assign do_push       = push_i && (!full || do_pop);
    assign occ_after_pop = count_q - {1'b0, do_pop};

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (clear_i) begin
            count_d = 2'd0;
        end else begin
            if (do_pop) begin
                ent0_d = ent1_q;
            end
            // The incoming word lands in the first slot left free after the pop.
            if (do_push) begin
                if (occ_after_pop == 2'd0) begin
                    ent0_d = '{instr: instr_i, pc: pc_i};
                end else begin
                    ent1_d = '{instr: instr_i, pc: pc_i};
                end
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign instr_o = ent0_q.instr;
    assign pc_o    = ent0_q.pc;
    assign valid_o = !empty;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, branch-target adder, request FSM, drop flag and 2-entry queue.
//   state | meaning
//   IDLE  | no request outstanding, waiting for a free queue slot
//   REQ   | IM_Req high, IM_Addr held until IM_Ack
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        IM_Req,
    output logic [31:0] IM_Addr,
    input  logic        IM_Ack,
    input  logic [31:0] IM_RData,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        BranchTaken,
    input  logic [31:0] BranchPC,
    input  logic [31:0] ExtImm
);

    localparam logic [1:0] DepthC = 2'(BUF_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         drop_q, drop_d;

    logic         ack, push, pop, slots_free;
    logic [1:0]   count, count_after;
    logic [31:0]  target;

    assign ack         = (state_q == REQ) && IM_Ack;
    assign pop         = InstrValid && InstrReady && !BranchTaken;
    assign push        = ack && !drop_q && !BranchTaken;
    assign count_after = BranchTaken ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
    assign slots_free  = (count_after < DepthC);
    assign target      = branch_target(BranchPC, ExtImm);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        if (BranchTaken) begin
            pc_d = target;
            // An un-acked request must complete at its original address; its data is dropped.
            if (state_q == REQ && !IM_Ack) begin
                drop_d = 1'b1;
            end else begin
                state_d = REQ;
                addr_d  = target;
                drop_d  = 1'b0;
            end
        end else if (state_q == IDLE) begin
            if (slots_free) begin
                state_d = REQ;
                addr_d  = pc_q;
            end
        end else if (IM_Ack) begin
            if (drop_q) begin
                drop_d = 1'b0;
                addr_d = pc_q;
            end else begin
                pc_d   = addr_q + 32'd4;
                addr_d = addr_q + 32'd4;
                if (!slots_free) begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    assign IM_Req  = (state_q == REQ);
    assign IM_Addr = addr_q;

    fetch_buffer u_buf (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .clear_i (BranchTaken),
        .push_i  (push),
        .pop_i   (pop),
        .instr_i (IM_RData),
        .pc_i    (addr_q),
        .instr_o (Instr),
        .pc_o    (InstrPC),
        .valid_o (InstrValid),
        .count_o (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against
// an in-order instruction-stream model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        IM_Req;
    logic [31:0] IM_Addr;
    logic        IM_Ack;
    logic [31:0] IM_RData;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic        BranchTaken;
    logic [31:0] BranchPC;
    logic [31:0] ExtImm;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .IM_Req      (IM_Req),
        .IM_Addr     (IM_Addr),
        .IM_Ack      (IM_Ack),
        .IM_RData    (IM_RData),
        .Instr       (Instr),
        .InstrPC     (InstrPC),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .BranchTaken (BranchTaken),
        .BranchPC    (BranchPC),
        .ExtImm      (ExtImm)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        IM_Ack      = 1'b0;
        IM_RData    = 32'h0;
        InstrReady  = 1'b0;
        BranchTaken = 1'b0;
        BranchPC    = 32'h0;
        ExtImm      = 32'h0;
    endtask

    // Leaves the bench one cycle after reset release, with the first request issued.
    task automatic apply_reset();
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    // Two acks with the decoder stalled: queue full, request FSM idle.
    task automatic fill_queue();
        apply_reset();
        IM_Ack   = 1'b1;
        IM_RData = 32'h0 ^ KEY;
        tick();
        IM_RData = 32'h4 ^ KEY;
        tick();
        IM_Ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({IM_Req, IM_Addr, InstrValid, Instr, InstrPC} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_values got req=%0b addr=%0h v=%0b instr=%0h pc=%0h exp 0/0/0/0/0",
                     IM_Req, IM_Addr, InstrValid, Instr, InstrPC);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if ({IM_Req, IM_Addr} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_first_req got req=%0b addr=%0h exp req=1 addr=0", IM_Req, IM_Addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        logic [31:0] p;
        apply_reset();
        InstrReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = 32'(4 * k);
            checks++;
            if ({IM_Req, IM_Addr} !== {1'b1, a}) begin
                failures++;
                $display("FAIL stream_addr k=%0d got req=%0b addr=%0h exp req=1 addr=%0h", k, IM_Req, IM_Addr, a);
            end
            if (k > 0) begin
                p = 32'(4 * (k - 1));
                checks++;
                if ({InstrValid, InstrPC, Instr} !== {1'b1, p, p ^ KEY}) begin
                    failures++;
                    $display("FAIL stream_instr k=%0d got v=%0b pc=%0h instr=%0h exp v=1 pc=%0h instr=%0h",
                             k, InstrValid, InstrPC, Instr, p, p ^ KEY);
                end
            end
            IM_Ack   = 1'b1;
            IM_RData = IM_Addr ^ KEY;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        apply_reset();
        IM_Ack   = 1'b1;
        IM_RData = 32'h0 ^ KEY;
        tick();
        checks++;
        if ({IM_Req, IM_Addr, InstrValid, InstrPC} !== {1'b1, 32'h4, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL stall_first got req=%0b addr=%0h v=%0b pc=%0h exp 1/4/1/0", IM_Req, IM_Addr, InstrValid, InstrPC);
        end
        IM_RData = 32'h4 ^ KEY;
        tick();
        checks++;
        if ({IM_Req, InstrValid, InstrPC, Instr} !== {1'b0, 1'b1, 32'h0, KEY}) begin
            failures++;
            $display("FAIL stall_full got req=%0b v=%0b pc=%0h instr=%0h exp 0/1/0/%0h", IM_Req, InstrValid, InstrPC, Instr, KEY);
        end
        IM_RData = 32'hDEAD_BEE0;
        tick();
        checks++;
        if ({IM_Req, InstrValid, InstrPC} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL stall_hold got req=%0b v=%0b pc=%0h exp 0/1/0", IM_Req, InstrValid, InstrPC);
        end
        IM_Ack     = 1'b0;
        InstrReady = 1'b1;
        tick();
        checks++;
        if ({IM_Req, IM_Addr, InstrValid, InstrPC, Instr} !== {1'b1, 32'h8, 1'b1, 32'h4, 32'h4 ^ KEY}) begin
            failures++;
            $display("FAIL stall_release got req=%0b addr=%0h v=%0b pc=%0h instr=%0h exp 1/8/1/4/%0h",
                     IM_Req, IM_Addr, InstrValid, InstrPC, Instr, 32'h4 ^ KEY);
        end
        idle_inputs();
    endtask

    task automatic test_branch_idle();
        fill_queue();
        BranchTaken = 1'b1;
        BranchPC    = 32'h100;
        ExtImm      = 32'hFFFF_FFF0;
        InstrReady  = 1'b1;
        tick();
        checks++;
        if ({InstrValid, IM_Req, IM_Addr} !== {1'b0, 1'b1, 32'h0F8}) begin
            failures++;
            $display("FAIL branch_idle_redirect got v=%0b req=%0b addr=%0h exp v=0 req=1 addr=f8", InstrValid, IM_Req, IM_Addr);
        end
        BranchTaken = 1'b0;
        IM_Ack      = 1'b1;
        IM_RData    = IM_Addr ^ KEY;
        tick();
        checks++;
        if ({InstrValid, InstrPC, Instr, IM_Addr} !== {1'b1, 32'h0F8, 32'h0F8 ^ KEY, 32'h0FC}) begin
            failures++;
            $display("FAIL branch_idle_target got v=%0b pc=%0h instr=%0h addr=%0h exp 1/f8/%0h/fc",
                     InstrValid, InstrPC, Instr, IM_Addr, 32'h0F8 ^ KEY);
        end
        idle_inputs();
    endtask

    task automatic test_branch_outstanding();
        logic hit;
        hit = 1'b0;
        apply_reset();
        InstrReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (IM_Addr == 32'h20) begin
                hit = 1'b1;
                break;
            end
            IM_Ack   = 1'b1;
            IM_RData = IM_Addr ^ KEY;
            tick();
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL branch_out_reach got addr=%0h exp addr=20 within 20 cycles", IM_Addr);
        end
        IM_Ack      = 1'b0;
        BranchTaken = 1'b1;
        BranchPC    = 32'h200;
        ExtImm      = 32'h40;
        tick();
        BranchTaken = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if ({IM_Req, IM_Addr, InstrValid} !== {1'b1, 32'h20, 1'b0}) begin
                failures++;
                $display("FAIL branch_out_hold j=%0d got req=%0b addr=%0h v=%0b exp 1/20/0", j, IM_Req, IM_Addr, InstrValid);
            end
            if (j == 2) begin
                IM_Ack   = 1'b1;
                IM_RData = ARM_NOP;
            end
            tick();
        end
        checks++;
        if ({IM_Req, IM_Addr, InstrValid} !== {1'b1, 32'h248, 1'b0}) begin
            failures++;
            $display("FAIL branch_out_drop got req=%0b addr=%0h v=%0b exp 1/248/0", IM_Req, IM_Addr, InstrValid);
        end
        IM_RData = 32'h248 ^ KEY;
        tick();
        checks++;
        if ({InstrValid, InstrPC, Instr} !== {1'b1, 32'h248, 32'h248 ^ KEY}) begin
            failures++;
            $display("FAIL branch_out_target got v=%0b pc=%0h instr=%0h exp 1/248/%0h", InstrValid, InstrPC, Instr, 32'h248 ^ KEY);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        apply_reset();
        BranchTaken = 1'b1;
        BranchPC    = 32'hFFFF_FFF8;
        ExtImm      = 32'h4;
        IM_Ack      = 1'b1;
        IM_RData    = 32'h0 ^ KEY;
        tick();
        checks++;
        if ({IM_Req, IM_Addr, InstrValid} !== {1'b1, 32'h4, 1'b0}) begin
            failures++;
            $display("FAIL wrap_target got req=%0b addr=%0h v=%0b exp 1/4/0", IM_Req, IM_Addr, InstrValid);
        end
        BranchTaken = 1'b0;
        IM_RData    = 32'h4 ^ KEY;
        InstrReady  = 1'b1;
        tick();
        checks++;
        if ({InstrValid, InstrPC, Instr} !== {1'b1, 32'h4, 32'h4 ^ KEY}) begin
            failures++;
            $display("FAIL wrap_fetch got v=%0b pc=%0h instr=%0h exp 1/4/%0h", InstrValid, InstrPC, Instr, 32'h4 ^ KEY);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        fill_queue();
        Reset       = 1'b1;
        IM_Ack      = 1'b1;
        IM_RData    = 32'h1234_5678;
        InstrReady  = 1'b1;
        BranchTaken = 1'b1;
        BranchPC    = 32'h100;
        tick();
        checks++;
        if ({IM_Req, IM_Addr, InstrValid, Instr, InstrPC} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_mid_values got req=%0b addr=%0h v=%0b instr=%0h pc=%0h exp 0/0/0/0/0",
                     IM_Req, IM_Addr, InstrValid, Instr, InstrPC);
        end
        idle_inputs();
        Reset = 1'b0;
        tick();
        checks++;
        if ({IM_Req, IM_Addr} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_mid_restart got req=%0b addr=%0h exp req=1 addr=0", IM_Req, IM_Addr);
        end
    endtask

    // Model: the decoder must see consecutive PCs, restarting at each branch target,
    // with each word equal to what memory returned for that PC.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_branch;
        logic        prev_stall;
        logic        br, ack, rdy;
        int          pops;
        apply_reset();
        exp_pc      = 32'h0;
        prev_addr   = 32'h0;
        prev_branch = 1'b0;
        prev_stall  = 1'b0;
        pops        = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (prev_branch) begin
                checks++;
                if (InstrValid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_flush cyc=%0d got v=%0b exp v=0", cyc, InstrValid);
                end
            end
            if (prev_stall) begin
                checks++;
                if ({IM_Req, IM_Addr} !== {1'b1, prev_addr}) begin
                    failures++;
                    $display("FAIL rnd_hold cyc=%0d got req=%0b addr=%0h exp req=1 addr=%0h", cyc, IM_Req, IM_Addr, prev_addr);
                end
            end
            if (InstrValid === 1'b1) begin
                checks++;
                if (Instr !== (InstrPC ^ KEY)) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got instr=%0h exp %0h", cyc, Instr, InstrPC ^ KEY);
                end
            end
            br  = ($urandom_range(0, 19) == 0);
            ack = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 65);
            BranchTaken = br;
            BranchPC    = $urandom() & 32'hFFFF_FFFC;
            ExtImm      = $urandom() & 32'hFFFF_FFFC;
            IM_Ack      = ack;
            IM_RData    = IM_Addr ^ KEY;
            InstrReady  = rdy;
            if (InstrValid === 1'b1 && rdy && !br) begin
                checks++;
                if (InstrPC !== exp_pc) begin
                    failures++;
                    $display("FAIL rnd_order cyc=%0d got pc=%0h exp pc=%0h", cyc, InstrPC, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (br) begin
                exp_pc = BranchPC + 32'd8 + ExtImm;
            end
            prev_branch = br;
            prev_stall  = (IM_Req === 1'b1) && !ack;
            prev_addr   = IM_Addr;
            tick();
        end
        checks++;
        if (pops < 200) begin
            failures++;
            $display("FAIL rnd_progress got pops=%0d exp at least 200", pops);
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_stall();
        test_branch_idle();
        test_branch_outstanding();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
